// File: rtl/gearbox_pkt_buf_if.sv
// Stream bundle around the packet buffer: gearbox word input and packet output.
interface gearbox_pkt_buf_if;
    logic [23:0] data_in;
    logic        data_in_last;
    logic        data_in_en;
    logic [23:0] m_data;
    logic        m_last;
    logic [15:0] m_len;
    logic        m_valid;
    logic        m_ready;

    modport master (
        output data_in, data_in_last, data_in_en, m_ready,
        input  m_data, m_last, m_len, m_valid
    );

    modport slave (
        input  data_in, data_in_last, data_in_en, m_ready,
        output m_data, m_last, m_len, m_valid
    );
endinterface

// File: rtl/gearbox_pkt_buf.sv
// Store-and-forward buffer behind the 32-to-24 gearbox: packets are released only
// once complete, oversize or unfittable packets are dropped whole and counted.
module gearbox_pkt_buf #(
    parameter int ADDR_W     = 9,
    parameter int LEN_ADDR_W = 4
) (
    input  logic             clk_out,
    input  logic             reset,
    gearbox_pkt_buf_if.slave bus,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      pkt_cnt
);
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int LQ_DEPTH = 1 << LEN_ADDR_W;

    typedef enum logic {ACCEPT, DROP} wr_state_e;
    wr_state_e state_q, state_d;

    logic [24:0] mem [DEPTH];
    logic [15:0] lq_mem [LQ_DEPTH];
    logic [24:0] mem_rdata;

    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
    logic [ADDR_W-1:0]     commit_vis_q, commit_vis_d, rd_ptr_q, rd_ptr_d, wr_ptr_inc;
    logic [15:0]           len_acc_q, len_acc_d, len_inc;
    logic [15:0]           drop_cnt_q, drop_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic [LEN_ADDR_W-1:0] lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d, lq_cnt_q, lq_cnt_d;
    logic                  first_q, first_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [23:0]           m_data_q, m_data_d;
    logic [15:0]           m_len_q, m_len_d;
    logic                  mem_we, lq_push, lq_pop, mem_full, lq_full, readable, load, xfer;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        commit_vis_d = wr_commit_q;
        rd_ptr_d     = rd_ptr_q;
        len_acc_d    = len_acc_q;
        drop_cnt_d   = drop_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        lq_wr_d      = lq_wr_q;
        lq_rd_d      = lq_rd_q;
        lq_cnt_d     = lq_cnt_q;
        first_d      = first_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        m_data_d     = m_data_q;
        m_len_d      = m_len_q;
        mem_we       = 1'b0;
        lq_push      = 1'b0;
        lq_pop       = 1'b0;

        wr_ptr_inc = wr_ptr_q + ADDR_W'(1);
        len_inc    = (len_acc_q == 16'hFFFF) ? len_acc_q : len_acc_q + 16'd1;
        mem_full   = (wr_ptr_inc == rd_ptr_q);
        lq_full    = (lq_cnt_q == {LEN_ADDR_W{1'b1}});

        case (state_q)
            ACCEPT: begin
                if (bus.data_in_en) begin
                    if (mem_full || (bus.data_in_last && lq_full)) begin
                        // rewind only to the last commit, so delivered-pending data survives
                        wr_ptr_d   = wr_commit_q;
                        drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
                        len_acc_d  = 16'd0;
                        if (!bus.data_in_last) state_d = DROP;
                    end else begin
                        mem_we    = 1'b1;
                        wr_ptr_d  = wr_ptr_inc;
                        len_acc_d = len_inc;
                        if (bus.data_in_last) begin
                            wr_commit_d = wr_ptr_inc;
                            lq_push     = 1'b1;
                            len_acc_d   = 16'd0;
                        end
                    end
                end
            end
            DROP: begin
                if (bus.data_in_en && bus.data_in_last) state_d = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase

        // Commits reach the read side a cycle late so the registered RAM read is never stale.
        readable = (rd_ptr_q != commit_vis_q);
        xfer     = m_valid_q && bus.m_ready;
        load     = readable && (!m_valid_q || bus.m_ready);

        if (load) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            m_valid_d = 1'b1;
            m_data_d  = mem_rdata[23:0];
            m_last_d  = mem_rdata[24];
            m_len_d   = first_q ? lq_mem[lq_rd_q] : 16'd0;
            lq_pop    = first_q;
            first_d   = mem_rdata[24];
        end else if (xfer) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_len_d   = 16'd0;
        end

        if (xfer && m_last_q) pkt_cnt_d = pkt_cnt_q + 16'd1;

        if (lq_push) lq_wr_d = lq_wr_q + LEN_ADDR_W'(1);
        if (lq_pop)  lq_rd_d = lq_rd_q + LEN_ADDR_W'(1);
        case ({lq_push, lq_pop})
            2'b10:   lq_cnt_d = lq_cnt_q + LEN_ADDR_W'(1);
            2'b01:   lq_cnt_d = lq_cnt_q - LEN_ADDR_W'(1);
            default: lq_cnt_d = lq_cnt_q;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state_q      <= ACCEPT;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            commit_vis_q <= '0;
            rd_ptr_q     <= '0;
            len_acc_q    <= '0;
            drop_cnt_q   <= '0;
            pkt_cnt_q    <= '0;
            lq_wr_q      <= '0;
            lq_rd_q      <= '0;
            lq_cnt_q     <= '0;
            first_q      <= 1'b1;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_data_q     <= '0;
            m_len_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            commit_vis_q <= commit_vis_d;
            rd_ptr_q     <= rd_ptr_d;
            len_acc_q    <= len_acc_d;
            drop_cnt_q   <= drop_cnt_d;
            pkt_cnt_q    <= pkt_cnt_d;
            lq_wr_q      <= lq_wr_d;
            lq_rd_q      <= lq_rd_d;
            lq_cnt_q     <= lq_cnt_d;
            first_q      <= first_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_data_q     <= m_data_d;
            m_len_q      <= m_len_d;
        end
    end

    // RAM with registered read addressed by the next read pointer.
    always_ff @(posedge clk_out) begin
        if (mem_we)  mem[wr_ptr_q]   <= {bus.data_in_last, bus.data_in};
        if (lq_push) lq_mem[lq_wr_q] <= len_inc;
        mem_rdata <= mem[rd_ptr_d];
    end

    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.m_len   = m_len_q;
    assign bus.m_valid = m_valid_q;
    assign drop_cnt    = drop_cnt_q;
    assign pkt_cnt     = pkt_cnt_q;
endmodule

// File: tb/tb_gearbox_pkt_buf.sv
// Bench for gearbox_pkt_buf with a 7-word data memory and 3-entry length queue.
module tb_gearbox_pkt_buf;
    logic        clk_out = 1'b0;
    logic        reset;
    logic [15:0] drop_cnt, pkt_cnt;

    gearbox_pkt_buf_if bus();

    gearbox_pkt_buf #(.ADDR_W(3), .LEN_ADDR_W(2)) dut (
        .clk_out (clk_out),
        .reset   (reset),
        .bus     (bus),
        .drop_cnt(drop_cnt),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk_out = ~clk_out;

    int tests = 0;
    int fails = 0;
    int exp_pkt = 0;
    int exp_drop = 0;
    logic [40:0] sb[$];   // {last, len, data}

    typedef struct {
        int          nwords;
        logic [23:0] base;
        int          gap;
        bit          kept;
        int          exp_pkt;
        int          exp_drop;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    task automatic send_pkt(input int n, input logic [23:0] base, input bit kept);
        logic [40:0] e;
        if (kept) begin
            for (int i = 0; i < n; i++) begin
                e = {(i == n - 1), (i == 0) ? 16'(n) : 16'd0, base + 24'(i)};
                sb.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            bus.data_in      = base + 24'(i);
            bus.data_in_last = (i == n - 1);
            bus.data_in_en   = 1'b1;
            tick();
        end
        bus.data_in_en   = 1'b0;
        bus.data_in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || bus.m_valid) && k < 100) begin
            tick();
            k++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!bus.m_valid && k < 50) begin
            tick();
            k++;
        end
        check("m_valid_rise", 64'(bus.m_valid), 64'd1);
    endtask

    // Scoreboard: every transfer is compared against the head of the expected queue.
    always @(negedge clk_out) begin
        if (!reset && bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %h expected none at %0t",
                         {bus.m_last, bus.m_len, bus.m_data}, $time);
            end else begin
                check("out_word", 64'({bus.m_last, bus.m_len, bus.m_data}), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 24'h000100, 0, 1'b1, 0, 0};
        vecs[1] = '{1, 24'h000101, 0, 1'b1, 0, 0};
        vecs[2] = '{1, 24'h000102, 0, 1'b1, 0, 0};
        vecs[3] = '{1, 24'h000103, 2, 1'b1, 5, 0};
        vecs[4] = '{7, 24'h000200, 2, 1'b1, 6, 0};
        vecs[5] = '{8, 24'h000300, 2, 1'b0, 6, 1};
        vecs[6] = '{10, 24'h000400, 2, 1'b0, 6, 2};
        vecs[7] = '{2, 24'hABCDE0, 0, 1'b1, 0, 0};
        vecs[8] = '{3, 24'hFFFFFE, 2, 1'b1, 8, 2};

        reset            = 1'b1;
        bus.data_in      = '0;
        bus.data_in_last = 1'b0;
        bus.data_in_en   = 1'b0;
        bus.m_ready      = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_last", 64'(bus.m_last), 64'd0);
        check("rst_m_data", 64'(bus.m_data), 64'd0);
        check("rst_m_len", 64'(bus.m_len), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

        // Latency: last word captured at edge N, m_valid at edge N+2.
        bus.m_ready = 1'b1;
        send_pkt(4, 24'h000001, 1'b1);
        check("lat_edge_n", 64'(bus.m_valid), 64'd0);
        tick();
        check("lat_edge_n1", 64'(bus.m_valid), 64'd0);
        tick();
        check("lat_edge_n2", 64'(bus.m_valid), 64'd1);
        wait_drain();
        check("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

        for (int v = 0; v < 9; v++) begin
            send_pkt(vecs[v].nwords, vecs[v].base, vecs[v].kept);
            if (vecs[v].gap > 0) begin
                repeat (vecs[v].gap) tick();
                wait_drain();
                check("vec_pkt_cnt", 64'(pkt_cnt), 64'(vecs[v].exp_pkt));
                check("vec_drop_cnt", 64'(drop_cnt), 64'(vecs[v].exp_drop));
            end
        end
        exp_pkt  = 8;
        exp_drop = 2;

        // Backpressure: first word held stable while m_ready is low.
        bus.m_ready = 1'b0;
        send_pkt(3, 24'h000001, 1'b1);
        wait_valid();
        for (int c = 0; c < 5; c++) begin
            check("hold_m_data", 64'(bus.m_data), 64'h000001);
            check("hold_m_len", 64'(bus.m_len), 64'd3);
            tick();
        end
        bus.m_ready = 1'b1;
        wait_drain();
        exp_pkt++;
        check("bp_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

        // Overflow: 5 + 4 words exceed 7 memory words plus the output stage.
        bus.m_ready = 1'b0;
        send_pkt(5, 24'h000010, 1'b1);
        send_pkt(4, 24'h000020, 1'b0);
        exp_drop++;
        check("ovf_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        bus.m_ready = 1'b1;
        wait_drain();
        exp_pkt++;
        check("ovf_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

        // Length queue full: A parks in the output stage, B..D fill the queue, E is dropped.
        bus.m_ready = 1'b0;
        send_pkt(1, 24'h000030, 1'b1);
        wait_valid();
        send_pkt(1, 24'h000031, 1'b1);
        send_pkt(1, 24'h000032, 1'b1);
        send_pkt(1, 24'h000033, 1'b1);
        send_pkt(1, 24'h000034, 1'b0);
        exp_drop++;
        check("lq_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        bus.m_ready = 1'b1;
        wait_drain();
        exp_pkt += 4;
        check("lq_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt));

        // Reset with a packet mid-output and another mid-write.
        bus.m_ready = 1'b0;
        send_pkt(2, 24'h000040, 1'b1);
        wait_valid();
        bus.data_in_en   = 1'b1;
        bus.data_in_last = 1'b0;
        bus.data_in      = 24'h000041;
        tick();
        bus.data_in      = 24'h000042;
        tick();
        bus.data_in_en   = 1'b0;
        reset            = 1'b1;
        sb.delete();
        tick();
        reset = 1'b0;
        check("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("mid_rst_m_len", 64'(bus.m_len), 64'd0);
        check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        check("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        bus.m_ready = 1'b1;
        send_pkt(2, 24'h000050, 1'b1);
        repeat (2) tick();
        wait_drain();
        check("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
        check("post_rst_drop_cnt", 64'(drop_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
